// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: brute-force key search sequencer for the arcfour core.
// Walks candidate keys KEY_FIRST..KEY_LAST, pulses core_start per key and
// collects the core's finished/success result; stops on the first success or
// when the range is exhausted.
// Optional build macro RC4_SEARCH_TIMEOUT_EN adds TIMEOUT_CYCLES and a sticky
// timeout output that bounds each WAIT; without it WAIT waits indefinitely.
module rc4_key_search_ctrl #(
  parameter int unsigned          KEY_WIDTH  = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_FIRST  = '0,
  parameter logic [KEY_WIDTH-1:0] KEY_LAST   = 24'h3FFFFF,
  parameter int unsigned          LAUNCH_GAP = 2
`ifdef RC4_SEARCH_TIMEOUT_EN
  ,
  parameter int unsigned          TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  output logic                 core_start,
  output logic [KEY_WIDTH-1:0] core_key,
  input  logic                 core_finished,
  input  logic                 core_success,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted,
  output logic [KEY_WIDTH-1:0] found_key,
  output logic [KEY_WIDTH-1:0] keys_tried
`ifdef RC4_SEARCH_TIMEOUT_EN
  ,
  output logic                 timeout
`endif
);

  localparam int unsigned GAP_W = (LAUNCH_GAP > 0) ? $clog2(LAUNCH_GAP + 1) : 1;

`ifdef RC4_SEARCH_TIMEOUT_EN
  localparam int unsigned TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] wait_cnt;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap_cnt;
  logic             success_q;

  // Search sequencer: state, key walk, result capture and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      core_start <= 1'b0;
      core_key   <= KEY_FIRST;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      found_key  <= '0;
      keys_tried <= '0;
      gap_cnt    <= '0;
      success_q  <= 1'b0;
`ifdef RC4_SEARCH_TIMEOUT_EN
      timeout    <= 1'b0;
      wait_cnt   <= '0;
`endif
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (start) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            keys_tried <= '0;
            core_key   <= KEY_FIRST;
            busy       <= 1'b1;
            state      <= S_LAUNCH;
`ifdef RC4_SEARCH_TIMEOUT_EN
            timeout    <= 1'b0;
`endif
          end
        end

        S_LAUNCH: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            core_start <= 1'b1;
            gap_cnt    <= GAP_W'(LAUNCH_GAP);
            state      <= S_WAIT;
`ifdef RC4_SEARCH_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end
        end

        S_WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            // core_finished may still be high from the previous run; it is
            // only trusted once the blanking gap has counted down.
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - 1'b1;
            end
            if (gap_cnt == '0 && core_finished) begin
              keys_tried <= keys_tried + 1'b1;
              success_q  <= core_success;
              state      <= S_CHECK;
            end
`ifdef RC4_SEARCH_TIMEOUT_EN
            else if (wait_cnt == TCNT_LAST) begin
              timeout <= 1'b1;
              busy    <= 1'b0;
              state   <= S_DONE;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
`endif
          end
        end

        S_CHECK: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (success_q) begin
            found     <= 1'b1;
            found_key <= core_key;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else if (core_key == KEY_LAST) begin
            exhausted <= 1'b1;
            busy      <= 1'b0;
            state     <= S_DONE;
          end else begin
            core_key <= core_key + 1'b1;
            state    <= S_LAUNCH;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Self-checking bench for rc4_key_search_ctrl with a behavioural arcfour model.
// Table of search scenarios plus hand-written abort/reset/timeout sequences.
// Expected core_key values are queued per search and popped on each core_start.
module tb_rc4_key_search_ctrl;

  localparam int FIN_DELAY = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        core_start;
  logic [23:0] core_key;
  logic        core_finished;
  logic        core_success;
  logic        busy;
  logic        found;
  logic        exhausted;
  logic [23:0] found_key;
  logic [23:0] keys_tried;
`ifdef RC4_SEARCH_TIMEOUT_EN
  logic        timeout;
`endif

  int checks = 0;
  int failures = 0;

  rc4_key_search_ctrl #(
    .KEY_WIDTH (24),
    .KEY_FIRST (24'd0),
    .KEY_LAST  (24'd15),
    .LAUNCH_GAP(2)
`ifdef RC4_SEARCH_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(64)
`endif
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .abort        (abort),
    .core_start   (core_start),
    .core_key     (core_key),
    .core_finished(core_finished),
    .core_success (core_success),
    .busy         (busy),
    .found        (found),
    .exhausted    (exhausted),
    .found_key    (found_key),
    .keys_tried   (keys_tried)
`ifdef RC4_SEARCH_TIMEOUT_EN
    ,
    .timeout      (timeout)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arcfour model: finishes FIN_DELAY cycles after core_start, succeeds for succ_key.
  logic        succ_en = 1'b0;
  logic [23:0] succ_key = '0;
  logic        hold_fin = 1'b0;
  logic        never_fin = 1'b0;
  logic        m_fin, m_succ;
  int          m_cnt;
  logic [23:0] m_key;

  assign core_finished = m_fin;
  assign core_success  = m_succ;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_fin <= 1'b0; m_succ <= 1'b0; m_cnt <= 0; m_key <= '0;
    end else if (core_start) begin
      m_cnt <= FIN_DELAY;
      m_key <= core_key;
      if (!hold_fin) m_fin <= 1'b0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        if (!never_fin) begin
          m_fin  <= 1'b1;
          m_succ <= succ_en && (m_key == succ_key);
        end
      end else begin
        m_fin <= 1'b0;
      end
    end
  end

  // Scoreboard / timing monitor, sampled on the falling edge.
  logic [23:0] exp_q[$];
  int  cyc = 0, start_cyc = 0, fin_cyc = 0, runs = 0;
  logic first_pending = 1'b0, have_fin = 1'b0, fin_prev = 1'b0;

  always @(negedge clk) begin
    logic [23:0] k;
    cyc++;
    if (reset_n) begin
      if (start && !busy && !abort) begin
        start_cyc = cyc; first_pending = 1'b1; have_fin = 1'b0; runs = 0;
      end
      if (core_finished && !fin_prev && busy) begin
        fin_cyc = cyc; have_fin = 1'b1;
      end
      if (core_start) begin
        if (exp_q.size() == 0) begin
          check("extra_core_start", {8'h0, core_key}, 32'hFFFF_FFFF);
        end else begin
          k = exp_q.pop_front();
          check("core_key", {8'h0, core_key}, {8'h0, k});
        end
        check("keys_tried_at_launch", {8'h0, keys_tried}, runs);
        runs++;
        if (first_pending) check("start_latency", cyc - start_cyc, 2);
        else if (have_fin) check("finish_to_start", cyc - fin_cyc, 3);
        first_pending = 1'b0;
        have_fin = 1'b0;
      end
    end
    fin_prev = core_finished;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic push_keys(input int first, input int last);
    for (int k = first; k <= last; k++) exp_q.push_back(24'(k));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    check(name, {31'h0, busy}, 0);
  endtask

  task automatic wait_launch(input logic [23:0] key, input int budget);
    logic seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (core_start && core_key == key) seen = 1'b1;
    end
    check("launch_seen", {31'h0, seen}, 1);
  endtask

  typedef struct {
    logic        s_en;
    logic [23:0] s_key;
    logic        hold;
    logic        e_found;
    logic        e_exh;
    logic [23:0] e_tried;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 24'd5,  1'b0, 1'b1, 1'b0, 24'd6};
    vecs[1] = '{1'b0, 24'd0,  1'b0, 1'b0, 1'b1, 24'd16};
    vecs[2] = '{1'b1, 24'd0,  1'b1, 1'b1, 1'b0, 24'd1};
    vecs[3] = '{1'b1, 24'd15, 1'b1, 1'b1, 1'b0, 24'd16};
    vecs[4] = '{1'b0, 24'd0,  1'b1, 1'b0, 1'b1, 24'd16};

    // Reset state
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_core_start", {31'h0, core_start}, 0);
    check("rst_core_key", {8'h0, core_key}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_found", {31'h0, found}, 0);
    check("rst_exhausted", {31'h0, exhausted}, 0);
    check("rst_found_key", {8'h0, found_key}, 0);
    check("rst_keys_tried", {8'h0, keys_tried}, 0);
`ifdef RC4_SEARCH_TIMEOUT_EN
    check("rst_timeout", {31'h0, timeout}, 0);
`endif

    // Table-driven searches
    for (int i = 0; i < 5; i++) begin
      succ_en = vecs[i].s_en; succ_key = vecs[i].s_key; hold_fin = vecs[i].hold;
      push_keys(0, int'(vecs[i].e_tried) - 1);
      pulse_start();
      check("busy_after_start", {31'h0, busy}, 1);
      wait_idle(1000, "row_done");
      repeat (30) @(negedge clk);
      check("row_found", {31'h0, found}, {31'h0, vecs[i].e_found});
      check("row_exhausted", {31'h0, exhausted}, {31'h0, vecs[i].e_exh});
      check("row_keys_tried", {8'h0, keys_tried}, {8'h0, vecs[i].e_tried});
      check("row_core_key", {8'h0, core_key}, {8'h0, vecs[i].e_tried - 24'd1});
      if (vecs[i].e_found) check("row_found_key", {8'h0, found_key}, {8'h0, vecs[i].s_key});
      check("row_queue_drained", exp_q.size(), 0);
    end
    hold_fin = 1'b0;

    // Reset mid-search: asynchronous return to reset values
    succ_en = 1'b0;
    push_keys(0, 4);
    pulse_start();
    wait_launch(24'd4, 200);
    #2 reset_n = 1'b0;
    #1;
    check("arst_busy", {31'h0, busy}, 0);
    check("arst_core_key", {8'h0, core_key}, 0);
    check("arst_keys_tried", {8'h0, keys_tried}, 0);
    check("arst_core_start", {31'h0, core_start}, 0);
    check("arst_found", {31'h0, found}, 0);
    check("arst_exhausted", {31'h0, exhausted}, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // start while busy is ignored: key sequence must stay continuous
    succ_en = 1'b1; succ_key = 24'd3;
    push_keys(0, 3);
    pulse_start();
    wait_launch(24'd1, 200);
    pulse_start();
    repeat (4) @(negedge clk);
    pulse_start();
    wait_idle(1000, "busy_start_done");
    check("busy_start_found_key", {8'h0, found_key}, 3);
    check("busy_start_keys_tried", {8'h0, keys_tried}, 4);
    check("busy_start_queue", exp_q.size(), 0);

    // abort in WAIT during key 3
    succ_en = 1'b0;
    push_keys(0, 3);
    pulse_start();
    wait_launch(24'd3, 200);
    repeat (3) @(negedge clk);
    pulse_abort();
    @(negedge clk);
    check("abort_busy", {31'h0, busy}, 0);
    check("abort_found", {31'h0, found}, 0);
    check("abort_exhausted", {31'h0, exhausted}, 0);
    check("abort_keys_tried", {8'h0, keys_tried}, 3);
    repeat (30) @(negedge clk);
    check("abort_queue", exp_q.size(), 0);
    succ_en = 1'b1; succ_key = 24'd2;
    push_keys(0, 2);
    pulse_start();
    wait_idle(1000, "restart_done");
    check("restart_found_key", {8'h0, found_key}, 2);
    check("restart_keys_tried", {8'h0, keys_tried}, 3);

    // start and abort together in DONE: abort wins, no new search
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    repeat (20) @(negedge clk);
    check("start_abort_busy", {31'h0, busy}, 0);
    check("start_abort_queue", exp_q.size(), 0);

    // abort coinciding with a CHECK success: abort wins
    succ_en = 1'b1; succ_key = 24'd0;
    push_keys(0, 0);
    pulse_start();
    wait_launch(24'd0, 50);
    begin
      int n = 0;
      @(negedge clk);
      while (!core_finished && n < 100) begin @(negedge clk); n++; end
      check("chk_fin_seen", {31'h0, core_finished}, 1);
    end
    pulse_abort();
    @(negedge clk);
    check("chk_abort_found", {31'h0, found}, 0);
    check("chk_abort_busy", {31'h0, busy}, 0);
    check("chk_abort_exhausted", {31'h0, exhausted}, 0);
    check("chk_abort_keys_tried", {8'h0, keys_tried}, 1);

`ifdef RC4_SEARCH_TIMEOUT_EN
    // core never finishes: timeout after 64 WAIT cycles
    never_fin = 1'b1; succ_en = 1'b0;
    push_keys(0, 0);
    pulse_start();
    wait_launch(24'd0, 50);
    begin
      int n = 0;
      while (busy && n < 200) begin @(negedge clk); n++; end
      check("timeout_latency", n, 64);
    end
    check("timeout_flag", {31'h0, timeout}, 1);
    check("timeout_found", {31'h0, found}, 0);
    check("timeout_exhausted", {31'h0, exhausted}, 0);
    never_fin = 1'b0; succ_en = 1'b1; succ_key = 24'd1;
    push_keys(0, 1);
    pulse_start();
    @(negedge clk);
    check("timeout_cleared", {31'h0, timeout}, 0);
    wait_idle(1000, "post_timeout_done");
    check("post_timeout_found_key", {8'h0, found_key}, 1);
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
